// File: rtl/cpu_pkg.sv
/******************************************************************************
 * Module : cpu_pkg
 * Shared opcodes, PC-select encodings and fetch FSM states for the CPU core.
 * Rev    : 1.0  initial release
 ******************************************************************************/
`default_nettype none

package cpu_pkg;

  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_JAL  = 4'b0000;
  localparam logic [3:0] OP_JALR = 4'b0001;
  localparam logic [3:0] OP_BEQ  = 4'b0010;
  localparam logic [3:0] OP_BLE  = 4'b0011;
  localparam logic [3:0] OP_LW   = 4'b0100;
  localparam logic [3:0] OP_SW   = 4'b0101;
  localparam logic [3:0] OP_ADD  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_SLL  = 4'b1011;
  localparam logic [3:0] OP_SRL  = 4'b1100;
  localparam logic [3:0] OP_ADDI = 4'b1101;
  localparam logic [3:0] OP_ANDI = 4'b1110;
  localparam logic [3:0] OP_ORI  = 4'b1111;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_REL = 2'b01;
  localparam logic [1:0] PC_REG = 2'b10;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_ISSUE = 2'd1,
    ST_EXEC  = 2'd2,
    ST_ERROR = 2'd3
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/pc_next_sel.sv
/******************************************************************************
 * Module : pc_next_sel
 * Selects the next PC from the ControlUnit's PCsrc and flags odd targets.
 * Rev    : 1.0  initial release
 ******************************************************************************/
`default_nettype none

module pc_next_sel
  import cpu_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic [1:0]    pcsrc,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] br_target,
  input  logic [AW-1:0] reg_target,
  output logic [AW-1:0] next_pc,
  output logic          misalign
);

  logic [AW-1:0] w_seq_pc;

  // Sequential step wraps modulo 2^AW.
  assign w_seq_pc = pc + AW'(2);

  always_comb begin
    next_pc = w_seq_pc;
    case (pcsrc)
      PC_SEQ:  next_pc = w_seq_pc;
      PC_REL:  next_pc = br_target;
      PC_REG:  next_pc = reg_target;
      default: next_pc = w_seq_pc;
    endcase
  end

  assign misalign = next_pc[0];

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
/******************************************************************************
 * Module : instr_fetch_unit
 * Multi-cycle fetch/issue/exec sequencer: owns the PC, fetches over req/ack.
 * Rev    : 1.0  initial release
 ******************************************************************************/
`default_nettype none

module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int            AW       = 16,
  parameter logic [AW-1:0] RESET_PC = 16'h0000,
  parameter int            TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [AW-1:0]      imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         op,
  output logic [AW-1:0]      pc_out,
  output logic [AW-1:0]      pc_plus2,
  input  logic               ex_valid,
  input  logic [1:0]         PCsrc,
  input  logic [AW-1:0]      br_target,
  input  logic [AW-1:0]      reg_target,
  output logic               fetch_err,
  output logic               align_err
);

  localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);

  fetch_state_t       r_state;
  fetch_state_t       w_state_nxt;
  logic [AW-1:0]      r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_req;
  logic [7:0]         r_cnt;
  logic               r_fetch_err;
  logic               r_align_err;
  logic [AW-1:0]      w_next_pc;
  logic               w_misalign;

  pc_next_sel #(.AW(AW)) u_pc_next_sel (
    .pcsrc      (PCsrc),
    .pc         (r_pc),
    .br_target  (br_target),
    .reg_target (reg_target),
    .next_pc    (w_next_pc),
    .misalign   (w_misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_FETCH;
    else        r_state <= w_state_nxt;
  end

  // r_req is low in FETCH only on the first edge after reset, so ack is ignored there.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FETCH: begin
        if (r_req) begin
          if (imem_ack)                 w_state_nxt = ST_ISSUE;
          else if (r_cnt == c_tmo_last) w_state_nxt = ST_ERROR;
        end
      end
      ST_ISSUE: if (instr_ready) w_state_nxt = ST_EXEC;
      ST_EXEC:  if (ex_valid)    w_state_nxt = w_misalign ? ST_ERROR : ST_FETCH;
      ST_ERROR: w_state_nxt = ST_ERROR;
      default:  w_state_nxt = ST_ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_instr     <= '0;
      r_req       <= 1'b0;
      r_cnt       <= 8'd0;
      r_fetch_err <= 1'b0;
      r_align_err <= 1'b0;
    end else begin
      r_req <= (w_state_nxt == ST_FETCH);
      if (r_state == ST_FETCH && r_req) begin
        if (imem_ack) begin
          r_instr <= imem_rdata;
          r_cnt   <= 8'd0;
        end else if (r_cnt == c_tmo_last) begin
          r_fetch_err <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
      if (r_state == ST_EXEC && ex_valid) begin
        if (w_misalign) r_align_err <= 1'b1;
        else            r_pc        <= w_next_pc;
      end
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign instr_valid = (r_state == ST_ISSUE);
  assign instr       = r_instr;
  assign op          = r_instr[15:12];
  assign pc_out      = r_pc;
  assign pc_plus2    = r_pc + AW'(2);
  assign fetch_err   = r_fetch_err;
  assign align_err   = r_align_err;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
/******************************************************************************
 * Module : tb_instr_fetch_unit
 * Directed bench with a cycle-level reference model for instr_fetch_unit.
 * Rev    : 1.0  initial release
 ******************************************************************************/
`default_nettype none

module tb_instr_fetch_unit;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr;
  logic [3:0]  op;
  logic [15:0] pc_out;
  logic [15:0] pc_plus2;
  logic        ex_valid = 1'b0;
  logic [1:0]  PCsrc = 2'b00;
  logic [15:0] br_target = 16'h0000;
  logic [15:0] reg_target = 16'h0000;
  logic        fetch_err;
  logic        align_err;

  always #5 clk = ~clk;

  instr_fetch_unit #(.AW(16), .RESET_PC(16'h0000), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .op(op),
    .pc_out(pc_out), .pc_plus2(pc_plus2),
    .ex_valid(ex_valid), .PCsrc(PCsrc), .br_target(br_target), .reg_target(reg_target),
    .fetch_err(fetch_err), .align_err(align_err)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc_n = 0;

  always @(posedge clk) cyc_n++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Reference model: phase of the single in-flight instruction.
  localparam int PH_FETCH = 0, PH_ISSUE = 1, PH_EXEC = 2, PH_DEAD = 3;
  int          m_ph = PH_FETCH;
  bit          m_live = 1'b0;
  int          m_wait = 0;
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] m_instr = 16'h0000;
  logic [15:0] m_tgt;
  bit          m_ferr = 1'b0;
  bit          m_aerr = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = PH_FETCH; m_live = 0; m_wait = 0; m_pc = 16'h0000;
      m_instr = 16'h0000; m_ferr = 0; m_aerr = 0;
    end else begin
      case (m_ph)
        PH_FETCH:
          if (!m_live) m_live = 1;
          else if (imem_ack) begin
            m_instr = imem_rdata; m_wait = 0; m_ph = PH_ISSUE;
          end else begin
            m_wait++;
            if (m_wait == TIMEOUT) begin m_ferr = 1; m_ph = PH_DEAD; end
          end
        PH_ISSUE: if (instr_ready) m_ph = PH_EXEC;
        PH_EXEC:
          if (ex_valid) begin
            if (PCsrc == 2'b01)      m_tgt = br_target;
            else if (PCsrc == 2'b10) m_tgt = reg_target;
            else                     m_tgt = 16'((32'(m_pc) + 2) % 65536);
            if (m_tgt % 2 == 1) begin m_aerr = 1; m_ph = PH_DEAD; end
            else begin m_pc = m_tgt; m_ph = PH_FETCH; end
          end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("imem_req", imem_req, (m_ph == PH_FETCH) && m_live);
      chk("instr_valid", instr_valid, m_ph == PH_ISSUE);
      chk("fetch_err", fetch_err, m_ferr);
      chk("align_err", align_err, m_aerr);
      if (m_ph == PH_FETCH && m_live) chk("imem_addr", imem_addr, m_pc);
      if (m_ph == PH_ISSUE) begin
        chk("instr", instr, m_instr);
        chk("op", op, m_instr / 4096);
        chk("pc_out", pc_out, m_pc);
        chk("pc_plus2", pc_plus2, 16'((32'(m_pc) + 2) % 65536));
      end
    end
  end

  // Responder: memory, decode and execute sides with programmable latencies.
  int ack_delay = 0, rdy_delay = 0, exv_delay = 0;
  bit ack_en = 1, stray = 0;
  int acnt = 0, rcnt = 0, ecnt = 0;
  bit exec_pend = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      imem_ack = 0; instr_ready = 0; ex_valid = 0;
      exec_pend = 0; acnt = 0; rcnt = 0; ecnt = 0;
    end else begin
      ex_valid = 0;
      if (exec_pend) begin
        if (ecnt >= exv_delay) begin ex_valid = 1; exec_pend = 0; end
        else ecnt++;
      end
      imem_ack = 0;
      if (imem_req) begin
        imem_rdata = 16'h8123 ^ imem_addr;
        imem_ack = ack_en && (acnt >= ack_delay);
        acnt = imem_ack ? 0 : acnt + 1;
      end else begin
        acnt = 0;
        imem_rdata = 16'($urandom);
      end
      instr_ready = 0;
      if (instr_valid) begin
        instr_ready = (rcnt >= rdy_delay);
        rcnt = instr_ready ? 0 : rcnt + 1;
        if (instr_ready) begin exec_pend = 1; ecnt = 0; end
      end else rcnt = 0;
      if (stray) begin
        if (instr_valid) imem_ack = 1;
        if (imem_req || instr_valid) ex_valid = 1;
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic wait_fetch(output logic [15:0] addr, output int t, output int nreq);
    addr = 16'h0000; t = 0; nreq = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (imem_req) nreq++;
      if (imem_req && imem_ack) begin addr = imem_addr; t = cyc_n; return; end
    end
    chk("fetch_wait_expired", 0, 1);
  endtask

  task automatic wait_issue();
    for (int i = 0; i < 200; i++) begin
      tick();
      if (instr_valid) return;
    end
    chk("issue_wait_expired", 0, 1);
  endtask

  task automatic do_reset(output int t_rel);
    rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
    t_rel = cyc_n;
  endtask

  logic [15:0] a;
  int t0, t1, nr, trel, cnt;

  initial begin
    do_reset(trel);
    // Sequential flow from reset.
    wait_fetch(a, t0, nr);
    chk("first_addr", a, 16'h0000);
    chk("first_req_cycle", t0 - trel, 1);
    wait_issue();
    chk("op_first", op, 4'b1000);
    chk("instr_first", instr, 16'h8123);
    wait_fetch(a, t1, nr);
    chk("seq_addr", a, 16'h0002);
    chk("seq_spacing", t1 - t0, 3);
    // Taken branch, then jalr.
    PCsrc = 2'b01; br_target = 16'h0040;
    wait_fetch(a, t0, nr);
    chk("beq_addr", a, 16'h0040);
    PCsrc = 2'b10; reg_target = 16'h0100;
    wait_issue();
    chk("jalr_link", pc_plus2, 16'h0042);
    wait_fetch(a, t0, nr);
    chk("jalr_addr", a, 16'h0100);
    // Backpressure on both memory and decode.
    PCsrc = 2'b00; ack_delay = 3; rdy_delay = 5;
    wait_fetch(a, t0, nr);
    chk("bp_addr", a, 16'h0102);
    chk("bp_req_cycles", nr, 4);
    wait_issue();
    cnt = 1;
    for (int i = 0; i < 20 && instr_valid; i++) begin tick(); if (instr_valid) cnt++; end
    chk("bp_issue_cycles", cnt, 6);
    wait_fetch(a, t0, nr);
    chk("bp_next_addr", a, 16'h0104);
    // Wrap at the top of the address space.
    ack_delay = 0; rdy_delay = 0;
    PCsrc = 2'b01; br_target = 16'hFFFE;
    wait_fetch(a, t0, nr);
    chk("wrap_pre_addr", a, 16'hFFFE);
    PCsrc = 2'b00;
    wait_issue();
    chk("wrap_link", pc_plus2, 16'h0000);
    wait_fetch(a, t0, nr);
    chk("wrap_addr", a, 16'h0000);
    // Stray handshakes outside their phases.
    stray = 1; rdy_delay = 3;
    wait_fetch(a, t0, nr);
    chk("stray_addr1", a, 16'h0002);
    wait_fetch(a, t0, nr);
    chk("stray_addr2", a, 16'h0004);
    stray = 0; rdy_delay = 0;
    // Ack lands on the last allowed cycle.
    ack_delay = TIMEOUT - 1;
    wait_fetch(a, t0, nr);
    chk("late_ack_addr", a, 16'h0006);
    chk("late_ack_req_cycles", nr, 15);
    wait_issue();
    chk("late_ack_no_err", fetch_err, 0);
    // Reset in the middle of a fetch.
    ack_delay = 5;
    for (int i = 0; i < 20 && !imem_req; i++) tick();
    tick();
    chk("mid_req_before", imem_req, 1);
    rst_n = 0; #1;
    chk("mid_req_dropped", imem_req, 0);
    chk("mid_valid_dropped", instr_valid, 0);
    tick();
    ack_delay = 0;
    rst_n = 1; trel = cyc_n;
    wait_fetch(a, t0, nr);
    chk("restart_addr", a, 16'h0000);
    chk("restart_cycle", t0 - trel, 1);
    // Odd redirect target.
    PCsrc = 2'b01; br_target = 16'h0041;
    wait_issue();
    for (int i = 0; i < 10 && !align_err; i++) tick();
    chk("align_err_set", align_err, 1);
    chk("align_pc_kept", pc_out, 16'h0000);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (imem_req) cnt++; end
    chk("align_no_req", cnt, 0);
    // Memory never answers.
    PCsrc = 2'b00; ack_en = 0;
    do_reset(trel);
    cnt = 0;
    for (int i = 0; i < 100 && !fetch_err; i++) begin tick(); if (imem_req) cnt++; end
    chk("timeout_req_cycles", cnt, 15);
    chk("timeout_err", fetch_err, 1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (imem_req) cnt++; end
    chk("timeout_req_stays_low", cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual running required done");
    $fatal(1);
  end

endmodule

`default_nettype wire
